usrt_tx_param: RTL and testbench
================================

Name: usrt_tx_param

Overview:
Parametrised synchronous-serial (USRT) transmitter. It buffers parallel words in an internal FIFO and shifts them out on TXD, timed by an externally supplied usrt_clk. The usrt_clk is sampled in the clk domain. The block raises RTS while data is pending, and adds configurable word width, parity, stop-bit count and a continuous or single-frame mode. It replaces the fixed 8-bit transmitter under top and drives the board RTS/TXD pins.

Parameters:
DATA_W, 8, payload bits per frame (5..16)
FIFO_DEPTH, 4, word buffer depth (power of 2, >=2)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
usrt_clk  in  1  external bit clock, asynchronous to clk, period >= 4 clk
wr_en  in  1  write strobe; one word per cycle
wr_data  in  DATA_W  word to transmit
single  in  1  1 = stop after each frame and re-arm; 0 = back-to-back frames
full  out  1  FIFO full; a write in this state is dropped
empty  out  1  FIFO empty
overflow  out  1  one-cycle pulse when a write is dropped
busy  out  1  high from leaving IDLE until returning to IDLE
RTS  out  1  request-to-send
TXD  out  1  serial data, idle high

Behaviour:
- Reset values: TXD=1, RTS=0, busy=0, full=0, empty=1, overflow=0. FIFO pointers cleared. FSM in IDLE. A reset mid-frame aborts the frame; TXD goes to 1 on the next cycle.
- usrt_clk path: 2-flop synchroniser plus a registered previous value. tick = one-clk pulse on a synchronised falling edge. TXD is updated only on tick cycles, so its latency is 3 clk after the usrt_clk fall. The receiver samples on the rising edge.
- FIFO: write when wr_en && !full; pop when the FSM loads the shifter.
  - Simultaneous write and pop while full: the write is dropped, because full is evaluated before the pop.
  - Simultaneous write and pop while empty: not possible, since a pop requires !empty.
  - Pointer wrap is modulo FIFO_DEPTH; the count is $clog2(FIFO_DEPTH)+1 bits wide.
- FSM states and transitions:
  - IDLE: when !empty, set RTS=1 and go to ARM.
  - ARM: wait one tick (guard bit, TXD=1). On that tick, pop the word into the shifter, drive TXD=0 (start bit) and go to DATA.
  - DATA: on each tick, drive shifter[0] (LSB first) and shift right. After DATA_W ticks, go to PAR if PARITY!=0, else go to STOP.
  - PAR: on tick, drive the parity bit. Even: XOR of the word. Odd: inverted XOR. The parity is computed at load time.
  - STOP: drive TXD=1 for STOP_BITS ticks. On the last stop tick:
    - if !single and !empty, pop the next word, drive the start bit in that same tick and go to DATA (no gap, RTS stays 1);
    - otherwise set RTS=0 and go to IDLE.
- busy=1 in every state except IDLE.
- The bit counter is $clog2(DATA_W+1) bits wide and is cleared when the word is loaded.

Decomposition:
- Shared package usrt_pkg holds:
  - localparams PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the FSM state enum (IDLE, ARM, DATA, PAR, STOP);
  - the function parity_bit(word, mode).
- One sub-module: usrt_fifo. It is a synchronous FIFO with parameters DATA_W and DEPTH and ports wr_en, wr_data, rd_en, rd_data, full, empty. The top level also holds the synchroniser, tick generator and FSM.

Test Plan:
- Reset held for 2 clk, then released. Expect TXD=1, RTS=0, empty=1, and no TXD change over 10 usrt_clk periods.
- DATA_W=8, PARITY=0, write 0xA5. Expect RTS to rise 1 clk after the write, then one guard tick. TXD then shows 0,1,0,1,0,0,1,0,1,1 on successive ticks, after which RTS=0 and busy=0.
- PARITY=2 (odd), write 0x03. Expect the parity bit to be 1. PARITY=1 (even) with the same word gives a parity bit of 0.
- single=0, write 0x01, 0x02, 0x03 back-to-back. Expect three frames with no idle tick between a stop bit and the next start bit, RTS high throughout, and empty=1 after the third pop.
- FIFO_DEPTH=4, 6 writes in consecutive cycles while TXD is idle. Expect full after the 4th write (or the 5th if ARM pops first) and an overflow pulse for each dropped write. Only accepted words are transmitted, in order.
- Assert rst in the middle of the DATA state. Expect TXD=1 and RTS=0 on the next clk, the FIFO emptied, and no further bits sent.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared definitions for the parametrised USRT transmitter:
// parity mode codes, FSM state encoding and the parity helper.
package usrt_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        DATA,
        PAR,
        STOP
    } usrt_state_t;

    // Word is zero-extended by the caller, so unused upper bits
    // do not disturb the XOR.
    function automatic logic parity_bit(
        input logic [15:0] word,
        input int          mode
    );
        logic x;
        x = ^word;
        if (mode == PAR_ODD) begin
            return ~x;
        end
        if (mode == PAR_EVEN) begin
            return x;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/usrt_fifo.sv
// Synchronous word FIFO feeding the USRT shifter.
// Ports: wr_en/wr_data push, rd_en pop, rd_data head word, full/empty flags.
module usrt_fifo
    import usrt_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_wr;
    logic              do_rd;

    // Flags come from the pre-pop count, so a write while full is
    // refused even if a pop happens in the same cycle.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/usrt_tx_param.sv
// Parametrised USRT transmitter: FIFO-buffered words shifted out LSB
// first on TXD, one bit per falling edge of the external usrt_clk.
// Ports: clk/rst, usrt_clk, wr_en/wr_data, single mode select,
// full/empty/overflow FIFO status, busy, RTS and TXD line outputs.
module usrt_tx_param
    import usrt_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              usrt_clk,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              single,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              busy,
    output logic              RTS,
    output logic              TXD
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [1:0] STOP_END = 2'(STOP_BITS);

    logic usrt_s1;
    logic usrt_s2;
    logic usrt_prev;
    logic tick;

    usrt_state_t       state, state_n;
    logic [DATA_W-1:0] shifter, shifter_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [1:0]        stop_cnt, stop_cnt_n;
    logic              par_r, par_n;
    logic              txd_r, txd_n;
    logic              rts_r, rts_n;
    logic              overflow_r;
    logic              load;
    logic              pop;
    logic [DATA_W-1:0] fifo_data;

    usrt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            usrt_s1   <= 1'b0;
            usrt_s2   <= 1'b0;
            usrt_prev <= 1'b0;
        end else begin
            usrt_s1   <= usrt_clk;
            usrt_s2   <= usrt_s1;
            usrt_prev <= usrt_s2;
        end
    end

    // Falling edge of the synchronised bit clock.
    assign tick = usrt_prev & ~usrt_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shifter    <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= '0;
            par_r      <= 1'b0;
            txd_r      <= 1'b1;
            rts_r      <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state      <= state_n;
            shifter    <= shifter_n;
            bit_cnt    <= bit_cnt_n;
            stop_cnt   <= stop_cnt_n;
            par_r      <= par_n;
            txd_r      <= txd_n;
            rts_r      <= rts_n;
            overflow_r <= wr_en && full;
        end
    end

    always_comb begin
        state_n    = state;
        shifter_n  = shifter;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par_r;
        txd_n      = txd_r;
        rts_n      = rts_r;
        load       = 1'b0;
        pop        = 1'b0;

        unique case (state)
            IDLE: begin
                if (!empty) begin
                    rts_n   = 1'b1;
                    state_n = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    load = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    txd_n     = shifter[0];
                    shifter_n = shifter >> 1;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_n = '0;
                        state_n    = (PARITY != PAR_NONE) ? PAR : STOP;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    txd_n      = par_r;
                    stop_cnt_n = '0;
                    state_n    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    // The tick after the final stop bit closes the
                    // frame; a queued word starts right here.
                    if (stop_cnt == STOP_END) begin
                        if (!single && !empty) begin
                            load = 1'b1;
                        end else begin
                            rts_n   = 1'b0;
                            state_n = IDLE;
                        end
                    end else begin
                        txd_n      = 1'b1;
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (load) begin
            pop       = 1'b1;
            shifter_n = fifo_data;
            par_n     = parity_bit(16'(fifo_data), PARITY);
            bit_cnt_n = '0;
            txd_n     = 1'b0;
            state_n   = DATA;
        end
    end

    assign busy     = (state != IDLE);
    assign RTS      = rts_r;
    assign TXD      = txd_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_usrt_tx_param.sv
// Scoreboard bench: three transmitters (no / even / odd parity) share
// stimulus; a line receiver per lane decodes TXD and checks each frame.
module tb_usrt_tx_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       usrt_clk = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       single = 1'b1;
    logic [2:0] full, empty, overflow, busy, rts, txd;

    int n_err = 0;
    int n_chk = 0;

    typedef struct {
        logic [7:0] w;
        bit         pe;
        bit         b2b;
    } exp_t;

    exp_t       sq [3][$];
    exp_t       cur [3];
    int         ph [3];
    int         nb [3];
    int         gap [3];
    logic [7:0] got [3];
    logic       gp [3];
    bit         sbad [3];
    bit         live [3];
    int         abort_gen = 0;
    int         seen_gen = 0;
    int         rts_rise [3];
    int         ovf_cnt [3];

    always #5 clk = ~clk;

    initial begin
        #2;
        forever #50 usrt_clk = ~usrt_clk;
    end

    usrt_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .rst(rst), .usrt_clk(usrt_clk), .wr_en(wr_en),
        .wr_data(wr_data), .single(single), .full(full[0]), .empty(empty[0]),
        .overflow(overflow[0]), .busy(busy[0]), .RTS(rts[0]), .TXD(txd[0]));

    usrt_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .rst(rst), .usrt_clk(usrt_clk), .wr_en(wr_en),
        .wr_data(wr_data), .single(single), .full(full[1]), .empty(empty[1]),
        .overflow(overflow[1]), .busy(busy[1]), .RTS(rts[1]), .TXD(txd[1]));

    usrt_tx_param #(.DATA_W(8), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .rst(rst), .usrt_clk(usrt_clk), .wr_en(wr_en),
        .wr_data(wr_data), .single(single), .full(full[2]), .empty(empty[2]),
        .overflow(overflow[2]), .busy(busy[2]), .RTS(rts[2]), .TXD(txd[2]));

    function automatic int lane_par(int l);
        return (l == 0) ? 0 : ((l == 1) ? 1 : 2);
    endfunction

    function automatic int lane_stop(int l);
        return (l == 2) ? 2 : 1;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_word(logic [7:0] w, bit pe, bit b2b);
        exp_t e;
        e.w = w;
        e.pe = pe;
        e.b2b = b2b;
        for (int l = 0; l < 3; l++) sq[l].push_back(e);
    endtask

    // Receiver: samples TXD on the rising bit-clock edge.
    task automatic rx_bit(int l, logic b);
        int np;
        int tot;
        bit expp;
        np = (lane_par(l) != 0) ? 1 : 0;
        tot = 8 + np + lane_stop(l);
        if (ph[l] == 0) begin
            if (b) begin
                gap[l]++;
            end else begin
                ph[l] = 1;
                nb[l] = 0;
                got[l] = 8'h00;
                gp[l] = 1'b0;
                sbad[l] = 1'b0;
                n_chk++;
                if (sq[l].size() == 0) begin
                    live[l] = 1'b0;
                    n_err++;
                    $display("FAIL lane%0d start: got unexpected frame want none", l);
                end else begin
                    cur[l] = sq[l].pop_front();
                    live[l] = 1'b1;
                    if (cur[l].b2b) begin
                        chk($sformatf("lane%0d gap", l), gap[l], 0);
                    end
                end
            end
        end else begin
            if (nb[l] < 8) got[l][nb[l]] = b;
            else if (np == 1 && nb[l] == 8) gp[l] = b;
            else if (b !== 1'b1) sbad[l] = 1'b1;
            nb[l]++;
            if (nb[l] == tot) begin
                ph[l] = 0;
                gap[l] = 0;
                if (live[l]) begin
                    chk($sformatf("lane%0d data", l), int'(got[l]), int'(cur[l].w));
                    if (np == 1) begin
                        expp = (lane_par(l) == 2) ? !cur[l].pe : cur[l].pe;
                        chk($sformatf("lane%0d parity", l), int'(gp[l]), int'(expp));
                    end
                    chk($sformatf("lane%0d stop", l), int'(sbad[l]), 0);
                end
            end
        end
    endtask

    initial begin
        for (int l = 0; l < 3; l++) begin
            ph[l] = 0;
            gap[l] = 0;
        end
        forever begin
            @(posedge usrt_clk);
            if (abort_gen != seen_gen) begin
                seen_gen = abort_gen;
                for (int l = 0; l < 3; l++) begin
                    sq[l].delete();
                    ph[l] = 0;
                    gap[l] = 0;
                end
            end
            for (int l = 0; l < 3; l++) rx_bit(l, txd[l]);
        end
    end

    initial begin
        logic [2:0] rts_q;
        rts_q = 3'b000;
        for (int l = 0; l < 3; l++) begin
            rts_rise[l] = 0;
            ovf_cnt[l] = 0;
        end
        forever begin
            @(negedge clk);
            for (int l = 0; l < 3; l++) begin
                if (rts[l] && !rts_q[l]) rts_rise[l]++;
                if (overflow[l]) ovf_cnt[l]++;
            end
            rts_q = rts;
        end
    end

    task automatic wait_idle(string name);
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        while (busy != 3'b000 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk({name, " idle"}, int'(busy), 0);
        repeat (15) @(posedge clk);
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("%s lane%0d pending", name, l), sq[l].size(), 0);
        end
    endtask

    initial begin
        int bad;
        int base [3];
        int n;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset txd", int'(txd), 7);
        chk("reset rts", int'(rts), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset empty", int'(empty), 7);
        chk("reset full", int'(full), 0);
        chk("reset overflow", int'(overflow), 0);

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 3'b111) bad++;
        end
        chk("idle txd", bad, 0);

        // single frame, RTS one clk after the write
        expect_word(8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        chk("rts before", int'(rts), 0);
        @(posedge clk);
        #1;
        chk("rts after", int'(rts), 7);
        wait_idle("a5");
        chk("a5 rts low", int'(rts), 0);

        expect_word(8'h03, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h03;
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("par03");

        // back-to-back frames
        for (int l = 0; l < 3; l++) base[l] = rts_rise[l];
        single = 1'b0;
        expect_word(8'h01, 1'b1, 1'b0);
        expect_word(8'h02, 1'b1, 1'b1);
        expect_word(8'h03, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'(i + 1);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("b2b");
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("b2b lane%0d rts rises", l), rts_rise[l] - base[l], 1);
        end
        chk("b2b empty", int'(empty), 7);
        single = 1'b1;

        // overflow: six writes, well clear of the next tick
        for (int l = 0; l < 3; l++) base[l] = ovf_cnt[l];
        expect_word(8'h11, 1'b0, 1'b0);
        expect_word(8'h12, 1'b0, 1'b0);
        expect_word(8'h13, 1'b1, 1'b0);
        expect_word(8'h14, 1'b0, 1'b0);
        @(posedge usrt_clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'(8'h11 + i);
            @(posedge clk);
            #1;
            if (i == 2) chk("full after 3", int'(full), 0);
            if (i == 3) chk("full after 4", int'(full), 7);
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("ovf");
        for (int l = 0; l < 3; l++) begin
            chk($sformatf("ovf lane%0d pulses", l), ovf_cnt[l] - base[l], 2);
        end

        // reset in the middle of DATA, second word still queued
        expect_word(8'h5A, 1'b0, 1'b0);
        expect_word(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        wr_en = 1'b1;
        wr_data = 8'h5A;
        @(negedge clk);
        wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        n = 0;
        while (rts != 3'b111 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("rst rts up", int'(rts), 7);
        repeat (4) @(posedge usrt_clk);
        chk("rst pre empty", int'(empty), 0);
        @(negedge clk);
        rst = 1'b1;
        abort_gen++;
        @(posedge clk);
        #1;
        chk("rst txd", int'(txd), 7);
        chk("rst rts", int'(rts), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst empty", int'(empty), 7);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (txd !== 3'b111 || rts !== 3'b000) bad++;
        end
        chk("post rst quiet", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
